// File: rtl/pixel_beat_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pixel_beat_fifo                                            |
// | Description : First-word-fall-through elastic buffer for 8-pixel RGB     |
// |               beats. Tags each stored beat with start-of-frame and       |
// |               end-of-line flags derived from a write-side raster counter,|
// |               and pulses frame_done when the last beat of a frame leaves.|
// | Ports       : aclk, areset         - clock, sync active-high reset       |
// |               frame_restart        - sync flush (same effect as reset)   |
// |               in_valid/in_ready    - write handshake, in_rgb payload     |
// |               out_valid/out_ready  - read handshake, head entry on       |
// |                                      out_rgb/out_sof/out_eol             |
// |               level                - occupancy 0..DEPTH                  |
// |               frame_done           - 1-cycle pulse after final pop       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pixel_beat_fifo #(
  parameter int X_SIZE       = 1024,
  parameter int Y_SIZE       = 576,
  parameter int PIX_PER_BEAT = 8,
  parameter int PIX_W        = 24,
  parameter int DEPTH        = 16
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic                            frame_restart,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [PIX_PER_BEAT*PIX_W-1:0]   in_rgb,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [PIX_PER_BEAT*PIX_W-1:0]   out_rgb,
  output logic                            out_sof,
  output logic                            out_eol,
  output logic [$clog2(DEPTH):0]          level,
  output logic                            frame_done
);

  localparam int DATA_W  = PIX_PER_BEAT * PIX_W;
  localparam int AW      = $clog2(DEPTH);
  localparam int LW      = AW + 1;
  // Entry layout: {last, eol, sof, rgb}
  localparam int ENTRY_W = DATA_W + 3;

  localparam logic [10:0]   WX_LAST    = 11'(X_SIZE - PIX_PER_BEAT);
  localparam logic [10:0]   WX_STEP    = 11'(PIX_PER_BEAT);
  localparam logic [9:0]    WY_LAST    = 10'(Y_SIZE - 1);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LEVEL_ONE  = LW'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [10:0]        wx;
  logic [9:0]         wy;
  logic [ENTRY_W-1:0] head;

  logic flush;
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic sof_tag;
  logic eol_tag;
  logic last_tag;

  assign flush    = areset | frame_restart;
  assign full     = (level == LEVEL_FULL);
  assign empty    = (level == '0);

  // in_ready deliberately ignores a same-cycle pop: no pass-through at full.
  assign in_ready = ~full & ~flush;
  // Derived from registered occupancy only, so no in_valid -> out_valid path.
  assign out_valid = ~empty;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  assign sof_tag  = (wx == '0) && (wy == '0);
  assign eol_tag  = (wx == WX_LAST);
  // Marks the final beat of the frame so frame_done needs no read-side counter.
  assign last_tag = eol_tag && (wy == WY_LAST);

  assign head     = mem[rd_ptr];
  assign out_rgb  = head[DATA_W-1:0];
  assign out_sof  = head[DATA_W];
  assign out_eol  = head[DATA_W+1];

  // Storage has no reset; stale entries are unreachable once level is 0.
  always_ff @(posedge aclk) begin
    if (push) begin
      mem[wr_ptr] <= {last_tag, eol_tag, sof_tag, in_rgb};
    end
  end

  always_ff @(posedge aclk) begin
    if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   level <= level + LEVEL_ONE;
        2'b01:   level <= level - LEVEL_ONE;
        default: level <= level;
      endcase
    end
  end

  // Write-side raster position, advanced once per accepted beat.
  always_ff @(posedge aclk) begin
    if (flush) begin
      wx <= '0;
      wy <= '0;
    end else if (push) begin
      if (eol_tag) begin
        wx <= '0;
        wy <= (wy == WY_LAST) ? '0 : wy + 10'd1;
      end else begin
        wx <= wx + WX_STEP;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (flush) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= pop & head[ENTRY_W-1];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pixel_beat_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_pixel_beat_fifo                                         |
// | Description : Scoreboard bench for pixel_beat_fifo. A feeder records     |
// |               every accepted beat with its expected tags (derived from   |
// |               the beat index since the last flush); a monitor checks the |
// |               head entry, occupancy and frame_done every cycle.          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_pixel_beat_fifo;

  localparam int X_SIZE = 1024;
  localparam int Y_SIZE = 576;
  localparam int PPB    = 8;
  localparam int PIX_W  = 24;
  localparam int DEPTH  = 16;
  localparam int DW     = PPB * PIX_W;
  localparam int LW     = $clog2(DEPTH) + 1;
  localparam int BPL    = X_SIZE / PPB;
  localparam int BPF    = BPL * Y_SIZE;

  logic          aclk = 1'b0;
  logic          areset;
  logic          frame_restart;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_rgb;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_rgb;
  logic          out_sof;
  logic          out_eol;
  logic [LW-1:0] level;
  logic          frame_done;

  pixel_beat_fifo #(
    .X_SIZE(X_SIZE), .Y_SIZE(Y_SIZE), .PIX_PER_BEAT(PPB), .PIX_W(PIX_W), .DEPTH(DEPTH)
  ) dut (
    .aclk(aclk), .areset(areset), .frame_restart(frame_restart),
    .in_valid(in_valid), .in_ready(in_ready), .in_rgb(in_rgb),
    .out_valid(out_valid), .out_ready(out_ready), .out_rgb(out_rgb),
    .out_sof(out_sof), .out_eol(out_eol), .level(level), .frame_done(frame_done)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [DW-1:0] rgb;
    logic          sof;
    logic          eol;
    logic          last;
  } beat_t;

  beat_t       sb[$];
  beat_t       fe;
  int          n_checks  = 0;
  int          n_fail    = 0;
  int          fd_count  = 0;
  int          nbeat     = 0;
  int          exp_lvl   = 0;
  bit          pushed_now = 1'b0;
  bit          fd_exp    = 1'b0;
  bit          acc       = 1'b0;
  logic [31:0] seq       = 32'd1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Feeder: records each beat the DUT is about to accept at the next edge.
  always @(negedge aclk) begin
    pushed_now = 1'b0;
    if (areset || frame_restart) begin
      sb.delete();
      nbeat = 0;
    end else if (in_valid && in_ready) begin
      fe.rgb  = in_rgb;
      fe.sof  = ((nbeat % BPF) == 0);
      fe.eol  = ((nbeat % BPL) == BPL - 1);
      fe.last = ((nbeat % BPF) == BPF - 1);
      sb.push_back(fe);
      nbeat++;
      pushed_now = 1'b1;
    end
  end

  // Monitor: compares the DUT head against the oldest scoreboard entry.
  always @(negedge aclk) begin
    #1;
    if (areset || frame_restart) begin
      fd_exp = 1'b0;
    end else begin
      chk("frame_done", DW'(frame_done), DW'(fd_exp));
      if (frame_done) fd_count++;
      fd_exp  = 1'b0;
      exp_lvl = sb.size() - int'(pushed_now);
      chk("level", DW'(level), DW'(exp_lvl));
      chk("out_valid", DW'(out_valid), DW'(exp_lvl != 0));
      if (out_valid && exp_lvl > 0) begin
        chk("head_rgb", out_rgb, sb[0].rgb);
        chk("head_sof", DW'(out_sof), DW'(sb[0].sof));
        chk("head_eol", DW'(out_eol), DW'(sb[0].eol));
        if (out_ready) begin
          fd_exp = sb[0].last;
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic send(input logic [DW-1:0] d);
    bit got = 1'b0;
    int t   = 0;
    in_valid = 1'b1;
    in_rgb   = d;
    while (!got && t < 200) begin
      @(negedge aclk);
      got = in_ready;
      @(posedge aclk);
      #1;
      t++;
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: actual in_ready=0 for %0d cycles required 1", t);
    end
    in_valid = 1'b0;
  endtask

  task automatic stream(input int n);
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      send({6{seq}});
      seq++;
    end
  endtask

  task automatic drain();
    int t = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge aclk); #2;
    while (out_valid && t < 100) begin
      @(negedge aclk); #2;
      t++;
    end
    chk("drain_empty", DW'(out_valid), '0);
    @(posedge aclk); #1;
  endtask

  // One-cycle flush (frame_restart or areset) with a beat offered alongside.
  task automatic pulse(input bit use_rst);
    in_valid = 1'b1;
    in_rgb   = {6{seq}};
    if (use_rst) areset = 1'b1;
    else         frame_restart = 1'b1;
    @(negedge aclk); #2;
    chk("flush_in_ready", DW'(in_ready), '0);
    @(posedge aclk); #1;
    areset        = 1'b0;
    frame_restart = 1'b0;
    in_valid      = 1'b0;
    @(negedge aclk); #2;
    chk("flush_level", DW'(level), '0);
    chk("flush_out_valid", DW'(out_valid), '0);
    chk("flush_frame_done", DW'(frame_done), '0);
    @(posedge aclk); #1;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: actual simulation still running required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    areset        = 1'b1;
    frame_restart = 1'b0;
    in_valid      = 1'b0;
    out_ready     = 1'b0;
    in_rgb        = '0;
    repeat (2) @(posedge aclk);
    @(negedge aclk); #2;
    chk("rst_in_ready", DW'(in_ready), '0);
    chk("rst_level", DW'(level), '0);
    chk("rst_out_valid", DW'(out_valid), '0);
    chk("rst_frame_done", DW'(frame_done), '0);
    @(posedge aclk); #1;
    areset = 1'b0;

    // Single beat into an empty FIFO
    send(192'hABCDEF);
    @(negedge aclk); #2;
    chk("t1_valid", DW'(out_valid), DW'(1));
    chk("t1_level", DW'(level), DW'(1));
    chk("t1_rgb", out_rgb, 192'hABCDEF);
    chk("t1_sof", DW'(out_sof), DW'(1));
    chk("t1_eol", DW'(out_eol), '0);
    @(posedge aclk); #1;
    out_ready = 1'b1;
    @(posedge aclk); #1;
    out_ready = 1'b0;
    @(negedge aclk); #2;
    chk("t1_pop_level", DW'(level), '0);
    chk("t1_pop_valid", DW'(out_valid), '0);
    @(posedge aclk); #1;

    // Fill to full, 17th beat waits for the cycle after the first pop
    for (int i = 0; i < DEPTH; i++) begin
      send({6{seq}});
      seq++;
    end
    @(negedge aclk); #2;
    chk("t2_full_level", DW'(level), DW'(DEPTH));
    chk("t2_full_ready", DW'(in_ready), '0);
    @(posedge aclk); #1;
    in_valid = 1'b1;
    in_rgb   = {6{seq}};
    repeat (2) begin
      @(negedge aclk); #2;
      chk("t2_hold_ready", DW'(in_ready), '0);
      @(posedge aclk); #1;
    end
    out_ready = 1'b1;
    @(negedge aclk); #2;
    chk("t2_pop_at_full_ready", DW'(in_ready), '0);
    @(posedge aclk); #1;
    out_ready = 1'b0;
    @(negedge aclk); #2;
    chk("t2_after_pop_level", DW'(level), DW'(DEPTH - 1));
    chk("t2_after_pop_ready", DW'(in_ready), DW'(1));
    @(posedge aclk); #1;
    in_valid = 1'b0;
    seq++;
    @(negedge aclk); #2;
    chk("t2_refill_level", DW'(level), DW'(DEPTH));
    @(posedge aclk); #1;
    drain();

    // Simultaneous push and pop at level 1
    out_ready = 1'b0;
    send({6{seq}});
    seq++;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_rgb   = {6{seq}};
      @(negedge aclk); #2;
      chk("t4_level", DW'(level), DW'(1));
      chk("t4_valid", DW'(out_valid), DW'(1));
      @(posedge aclk); #1;
      seq++;
    end
    in_valid = 1'b0;
    drain();

    // Full frame: tags on every beat, single frame_done pulse
    pulse(1'b0);
    fd_count = 0;
    stream(BPF + 1);
    drain();
    repeat (2) @(posedge aclk);
    #1;
    chk("frame_done_count", DW'(fd_count), DW'(1));

    // Mid-frame restart with a beat offered in the restart cycle
    pulse(1'b0);
    stream(300);
    pulse(1'b0);
    stream(BPL + 1);
    drain();

    // Random back-pressure around level 5, then areset mid-stream
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send({6{seq}});
      seq++;
    end
    for (int i = 0; i < 80; i++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 2) == 0);
      in_rgb    = {6{seq}};
      @(negedge aclk);
      acc = in_valid & in_ready;
      @(posedge aclk); #1;
      if (acc) seq++;
    end
    pulse(1'b1);
    stream(3);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pixel_beat_fifo.md
Name: pixel_beat_fifo

Overview:
- Elastic buffer between the SIMD processor display outputs and the pixel packer.
- Accepts 8-pixel RGB beats (192 bits) on a valid/ready handshake and stores them in a first-word-fall-through FIFO.
- Tracks the frame raster position on the write side and tags each stored beat with start-of-frame and end-of-line flags.
- The packer consumes the tags directly, so frame position no longer has to be derived from its own handshake.

Parameters:
- X_SIZE, 1024, active pixels per line; must be a multiple of PIX_PER_BEAT.
- Y_SIZE, 576, lines per frame.
- PIX_PER_BEAT, 8, pixels per beat.
- PIX_W, 24, bits per pixel (RGB888).
- DEPTH, 16, FIFO entries; power of two, at least 2.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  synchronous reset, active-high.
- frame_restart  in  1  synchronous flush, active-high; GPU frame reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  FIFO can accept a beat.
- in_rgb  in  PIX_PER_BEAT*PIX_W (192)  input pixels; pixel 0 in bits [23:0].
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts the head entry.
- out_rgb  out  192  head entry pixels.
- out_sof  out  1  head entry is the first beat of a frame (x=0, y=0).
- out_eol  out  1  head entry is the last beat of a line.
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- frame_done  out  1  one-cycle pulse when the final beat of a frame is popped.

Behaviour:
- Handshakes:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ready = ~full & ~areset & ~frame_restart (combinational).
  - out_valid = ~empty (registered state, no combinational path from in_valid).
- Storage: DEPTH x (192+2) entries, written with {eol_tag, sof_tag, in_rgb}. Write pointer and read pointer are each $clog2(DEPTH) bits and wrap modulo DEPTH. Occupancy is tracked in level.
- Write-side raster counters: wx is 11 bits in pixel units, wy is 10 bits. Both reset to 0.
  - sof_tag = (wx==0) & (wy==0).
  - eol_tag = (wx==X_SIZE-PIX_PER_BEAT).
  - On push:
    - If eol_tag: wx<=0. Then wy<=0 if wy==Y_SIZE-1, otherwise wy<=wy+1.
    - Otherwise: wx<=wx+PIX_PER_BEAT.
- Latency:
  - A beat pushed into an empty FIFO at edge N appears on out_* (out_valid=1) after edge N.
  - No fall-through in the push cycle itself.
- out_rgb, out_sof and out_eol reflect the head entry.
  - They must hold stable while out_valid=1 and out_ready=0.
  - They are don't-care when out_valid=0.
- Level updates:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop in the same cycle: unchanged, and both pointers advance.
- Full (level==DEPTH): in_ready=0, even if a pop occurs in the same cycle. There is no pass-through at full.
- Empty (level==0): out_valid=0, and out_ready is ignored.
- frame_done: registered. It goes to 1 in the cycle after a pop whose entry has eol=1 and was written with wy==Y_SIZE-1. A per-entry "last" bit may be stored for this.
- areset and frame_restart: identical effect. At the next edge:
  - Pointers, level, wx and wy return to 0.
  - out_valid=0 and frame_done=0.
  - Stored data is discarded.
  - in_ready=0 during the asserting cycle, so any in_valid presented then is dropped and not counted.
  - A mid-frame restart makes the next accepted beat carry sof=1.
- Reset values: out_valid=0, in_ready=0 while areset=1, level=0, frame_done=0. out_rgb, out_sof and out_eol are don't-care.

Test Plan:
- Push one beat 0x…ABCDEF into an empty FIFO at edge 1 -> out_valid=1 after edge 1, out_rgb=0x…ABCDEF, out_sof=1, out_eol=0, level=1. Pop -> level=0, out_valid=0.
- Hold out_ready=0 and push 16 beats -> level=16, in_ready=0. A 17th beat held on in_valid is accepted only in the cycle after the first pop, and data order is preserved.
- Stream beats with out_ready=1 -> beat 127 (wx=1016) has out_eol=1 and beat 128 has out_sof=0. After 73728 beats (128x576) the next beat has out_sof=1, and frame_done pulses exactly once, one cycle after beat 73727 is popped.
- Level=1 with simultaneous push and pop for 10 cycles -> level stays 1, out_valid stays 1, and output data follows input order with one beat of delay.
- Push 300 beats (mid line 2), then assert frame_restart for 1 cycle with in_valid=1 -> that beat is dropped, level=0, out_valid=0. The next accepted beat has out_sof=1 and the eol cadence restarts (eol on beat 127 after restart).
- Hold out_ready low for random stretches at level 5 -> out_rgb, out_sof and out_eol never change while out_valid=1 and out_ready=0. Assert areset mid-stream -> identical result to frame_restart.
